// File: rtl/stream_decoder_top.sv
`timescale 1ns/1ps
// Stego video decoder: passes video through a 2-entry skid buffer and recovers LSB-packed message bytes; STREAM_DECODER_DROP_CNT_EN adds msg_drop_cnt.
// Latency: 1 cycle from accepted beat to m00 valid; 1 cycle from completed byte to m01 valid.
// Backpressure: s00 stalls only when the video skid buffer is full; a full message FIFO drops bytes instead of stalling video.

module stream_decoder_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_drop,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             push;
    logic             pop;

    assign full    = (count == CNT_FULL);
    assign rd_vld  = (count != '0);
    assign pop     = rd_vld && rd_rdy;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push    = wr_vld && (!full || pop);
    assign wr_drop = wr_vld && full && !pop;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end
endmodule

module stream_decoder_top #(
    parameter int BITS_PER_PIX    = 24,
    parameter int PIXELS_PER_LINE = 1920,
    parameter int LINES_PER_FRAME = 1080,
    parameter int MSG_FIFO_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    s00_axis_tvalid,
    output logic                    s00_axis_tready,
    input  logic [BITS_PER_PIX-1:0] s00_axis_tdata,
    input  logic                    s00_axis_tlast,
    input  logic [2:0]              s00_axis_tkeep,
    input  logic                    s00_axis_tuser,
    output logic                    m00_axis_tvalid,
    input  logic                    m00_axis_tready,
    output logic [BITS_PER_PIX-1:0] m00_axis_tdata,
    output logic                    m00_axis_tlast,
    output logic [2:0]              m00_axis_tkeep,
    output logic                    m00_axis_tuser,
    output logic                    m01_axis_tvalid,
    output logic [7:0]              m01_axis_tdata,
    output logic                    m01_axis_tlast,
    input  logic                    m01_axis_tready,
    output logic                    msg_overflow
`ifdef STREAM_DECODER_DROP_CNT_EN
    ,
    output logic [15:0]             msg_drop_cnt
`endif
);
    localparam int PW = (PIXELS_PER_LINE > 1) ? $clog2(PIXELS_PER_LINE) : 1;
    localparam int LW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
    localparam logic [PW-1:0] PIX_LAST  = PW'(PIXELS_PER_LINE - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(LINES_PER_FRAME - 1);
    localparam logic [PW-1:0] PIX_ONE   = PW'(1);
    localparam logic [LW-1:0] LINE_ONE  = LW'(1);

    typedef struct packed {
        logic [BITS_PER_PIX-1:0] tdata;
        logic                    tlast;
        logic [2:0]              tkeep;
        logic                    tuser;
    } beat_t;

    // Video skid buffer: buf0 is always the head presented on m00.
    beat_t      in_beat;
    beat_t      buf0;
    beat_t      buf1;
    logic [1:0] vid_cnt;
    logic       rdy_en;
    logic       vid_push;
    logic       vid_pop;

    assign in_beat         = {s00_axis_tdata, s00_axis_tlast, s00_axis_tkeep, s00_axis_tuser};
    assign s00_axis_tready = rdy_en && (vid_cnt != 2'd2);
    assign vid_push        = s00_axis_tvalid && s00_axis_tready;
    assign m00_axis_tvalid = (vid_cnt != 2'd0);
    assign vid_pop         = m00_axis_tvalid && m00_axis_tready;
    assign m00_axis_tdata  = buf0.tdata;
    assign m00_axis_tlast  = buf0.tlast;
    assign m00_axis_tkeep  = buf0.tkeep;
    assign m00_axis_tuser  = buf0.tuser;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_en  <= 1'b0;
            vid_cnt <= 2'd0;
            buf0    <= '0;
            buf1    <= '0;
        end else begin
            rdy_en <= 1'b1;
            case ({vid_push, vid_pop})
                2'b10: begin
                    if (vid_cnt == 2'd0) begin
                        buf0 <= in_beat;
                    end else begin
                        buf1 <= in_beat;
                    end
                    vid_cnt <= vid_cnt + 2'd1;
                end
                2'b01: begin
                    buf0    <= buf1;
                    vid_cnt <= vid_cnt - 2'd1;
                end
                2'b11: begin
                    if (vid_cnt == 2'd1) begin
                        buf0 <= in_beat;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= in_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    // Message extraction; a tuser beat restarts position and byte alignment on itself.
    logic [PW-1:0] pix_cnt;
    logic [PW-1:0] cur_pix;
    logic [LW-1:0] line_cnt;
    logic [LW-1:0] cur_line;
    logic [7:0]    shift_reg;
    logic [7:0]    base_sr;
    logic [7:0]    new_sr;
    logic [2:0]    bit_cnt;
    logic [2:0]    base_cnt;
    logic          line_end;
    logic          frame_end;
    logic          byte_done;
    logic          msg_push;
    logic          msg_drop;
    logic [8:0]    msg_rd_dat;

    always_comb begin
        cur_pix   = s00_axis_tuser ? '0 : pix_cnt;
        cur_line  = s00_axis_tuser ? '0 : line_cnt;
        base_sr   = s00_axis_tuser ? 8'h00 : shift_reg;
        base_cnt  = s00_axis_tuser ? 3'd0 : bit_cnt;
        new_sr    = base_sr;
        new_sr[3'd7 - base_cnt] = s00_axis_tdata[0];
        byte_done = (base_cnt == 3'd7);
        line_end  = s00_axis_tlast || (cur_pix == PIX_LAST);
        frame_end = s00_axis_tlast && (cur_line == LINE_LAST);
        msg_push  = vid_push && (byte_done || frame_end);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_cnt   <= '0;
            line_cnt  <= '0;
            shift_reg <= 8'h00;
            bit_cnt   <= 3'd0;
        end else if (vid_push) begin
            pix_cnt <= line_end ? '0 : cur_pix + PIX_ONE;
            if (line_end) begin
                line_cnt <= (cur_line == LINE_LAST) ? '0 : cur_line + LINE_ONE;
            end else begin
                line_cnt <= cur_line;
            end
            if (byte_done || frame_end) begin
                shift_reg <= 8'h00;
                bit_cnt   <= 3'd0;
            end else begin
                shift_reg <= new_sr;
                bit_cnt   <= base_cnt + 3'd1;
            end
        end
    end

    stream_decoder_fifo #(
        .WIDTH (9),
        .DEPTH (MSG_FIFO_DEPTH)
    ) u_msg_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_vld  (msg_push),
        .wr_dat  ({frame_end, new_sr}),
        .wr_drop (msg_drop),
        .rd_vld  (m01_axis_tvalid),
        .rd_rdy  (m01_axis_tready),
        .rd_dat  (msg_rd_dat)
    );

    assign {m01_axis_tlast, m01_axis_tdata} = msg_rd_dat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            msg_overflow <= 1'b0;
        end else if (msg_drop) begin
            msg_overflow <= 1'b1;
        end
    end

`ifdef STREAM_DECODER_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            msg_drop_cnt <= 16'h0000;
        end else if (msg_drop && (msg_drop_cnt != 16'hFFFF)) begin
            msg_drop_cnt <= msg_drop_cnt + 16'h0001;
        end
    end
`endif
endmodule

// File: tb/tb_stream_decoder_top.sv
`timescale 1ns/1ps
// Directed bench: dut_a is a 4x2 frame decoder, dut_b a 4x1 frame decoder, both fed the same stream.
module tb_stream_decoder_top;
    localparam int BPP = 24;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           s_vld, s_last, s_user;
    logic [BPP-1:0] s_dat;
    logic [2:0]     s_keep;
    logic           m00_rdy, m01_rdy, rdy_set, tgl, phase;
    logic [15:0]    seq;

    logic           a_s_rdy, a_m00_vld, a_m00_last, a_m00_user, a_m01_vld, a_m01_last, a_ovf;
    logic [BPP-1:0] a_m00_dat;
    logic [2:0]     a_m00_keep;
    logic [7:0]     a_m01_dat;
    logic           b_s_rdy, b_m00_vld, b_m00_last, b_m00_user, b_m01_vld, b_m01_last, b_ovf;
    logic [BPP-1:0] b_m00_dat;
    logic [2:0]     b_m00_keep;
    logic [7:0]     b_m01_dat;
`ifdef STREAM_DECODER_DROP_CNT_EN
    logic [15:0]    a_drop, b_drop;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always begin
        @(posedge clk);
        #1 phase = ~phase;
    end
    assign m00_rdy = tgl ? phase : rdy_set;

    stream_decoder_top #(.BITS_PER_PIX(BPP), .PIXELS_PER_LINE(4), .LINES_PER_FRAME(2), .MSG_FIFO_DEPTH(4)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .s00_axis_tvalid(s_vld), .s00_axis_tready(a_s_rdy), .s00_axis_tdata(s_dat),
        .s00_axis_tlast(s_last), .s00_axis_tkeep(s_keep), .s00_axis_tuser(s_user),
        .m00_axis_tvalid(a_m00_vld), .m00_axis_tready(m00_rdy), .m00_axis_tdata(a_m00_dat),
        .m00_axis_tlast(a_m00_last), .m00_axis_tkeep(a_m00_keep), .m00_axis_tuser(a_m00_user),
        .m01_axis_tvalid(a_m01_vld), .m01_axis_tdata(a_m01_dat), .m01_axis_tlast(a_m01_last),
        .m01_axis_tready(m01_rdy), .msg_overflow(a_ovf)
`ifdef STREAM_DECODER_DROP_CNT_EN
        , .msg_drop_cnt(a_drop)
`endif
    );

    stream_decoder_top #(.BITS_PER_PIX(BPP), .PIXELS_PER_LINE(4), .LINES_PER_FRAME(1), .MSG_FIFO_DEPTH(4)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .s00_axis_tvalid(s_vld), .s00_axis_tready(b_s_rdy), .s00_axis_tdata(s_dat),
        .s00_axis_tlast(s_last), .s00_axis_tkeep(s_keep), .s00_axis_tuser(s_user),
        .m00_axis_tvalid(b_m00_vld), .m00_axis_tready(m00_rdy), .m00_axis_tdata(b_m00_dat),
        .m00_axis_tlast(b_m00_last), .m00_axis_tkeep(b_m00_keep), .m00_axis_tuser(b_m00_user),
        .m01_axis_tvalid(b_m01_vld), .m01_axis_tdata(b_m01_dat), .m01_axis_tlast(b_m01_last),
        .m01_axis_tready(m01_rdy), .msg_overflow(b_ovf)
`ifdef STREAM_DECODER_DROP_CNT_EN
        , .msg_drop_cnt(b_drop)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: video scoreboard plus capture of every popped message byte.
    typedef logic [BPP+4:0] beat_t;
    beat_t      exp_q[$];
    logic [8:0] got_a[$];
    logic [8:0] got_b[$];
    logic       lat_en = 1'b0;
    logic       t5_en = 1'b0;
    logic       prev_acc = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            prev_acc = 1'b0;
        end else begin
            if (t5_en) chk("t5_rdy_only_when_full", a_s_rdy, exp_q.size() < 2);
            if (lat_en && prev_acc) chk("t1_latency", a_m00_vld, 1'b1);
            if (a_m00_vld && m00_rdy) begin
                if (exp_q.size() == 0) chk("vid_spurious_beat", a_m00_vld, 1'b0);
                else chk("vid_beat", {a_m00_dat, a_m00_last, a_m00_keep, a_m00_user}, exp_q.pop_front());
            end
            prev_acc = s_vld && a_s_rdy;
            if (prev_acc) exp_q.push_back({s_dat, s_last, s_keep, s_user});
            if (a_m01_vld && m01_rdy) got_a.push_back({a_m01_last, a_m01_dat});
            if (b_m01_vld && m01_rdy) got_b.push_back({b_m01_last, b_m01_dat});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_vld = 1'b0; s_last = 1'b0; s_user = 1'b0; s_dat = '0; s_keep = '0;
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
    endtask

    task automatic send(input logic lsb, input logic last, input logic user);
        int n;
        s_vld  = 1'b1;
        s_dat  = {seq ^ 16'hA5C3, seq[6:0], lsb};
        s_keep = seq[2:0];
        s_last = last;
        s_user = user;
        seq    = seq + 16'd1;
        n = 0;
        @(negedge clk);
        while (!a_s_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", a_s_rdy, 1'b1);
        @(posedge clk);
        #1 s_vld = 1'b0;
    endtask

    // bits are sent MSB first; ppl=0 puts tlast on the final beat only
    task automatic send_bits(input logic [15:0] bits, input int n, input int ppl, input bit user);
        for (int i = 0; i < n; i++) begin
            send(bits[n-1-i], (ppl != 0) ? ((i % ppl) == ppl - 1) : (i == n - 1), user && (i == 0));
        end
    endtask

    task automatic expect_byte(input string tag, input bit use_b, input int idx, input logic [8:0] exp);
        int sz;
        sz = use_b ? got_b.size() : got_a.size();
        if (sz > idx) chk(tag, use_b ? got_b[idx] : got_a[idx], exp);
        else chk({tag, "_missing"}, sz, idx + 1);
    endtask

    initial begin
        int ba;
        int bb;
        logic [7:0] v;
        seq = 16'h0; phase = 1'b0; tgl = 1'b0; rdy_set = 1'b1; m01_rdy = 1'b1;
        s_vld = 1'b0; s_last = 1'b0; s_user = 1'b0; s_dat = '0; s_keep = '0;
        reset_n = 1'b0;
        #12;
        chk("rst_s00_tready", a_s_rdy, 1'b0);
        chk("rst_m00_tvalid", a_m00_vld, 1'b0);
        chk("rst_m01_tvalid", a_m01_vld, 1'b0);
        chk("rst_overflow", a_ovf, 1'b0);
        chk("rst_m00_data", {a_m00_dat, a_m00_last, a_m00_keep, a_m00_user}, '0);
        chk("rst_m01_data", {a_m01_last, a_m01_dat}, '0);
`ifdef STREAM_DECODER_DROP_CNT_EN
        chk("rst_drop_cnt", a_drop, 16'h0);
`endif
        idle(2);
        reset_n = 1'b1;
        #1 chk("rdy_after_release", a_s_rdy, 1'b0);
        idle(1);
        chk("rdy_first_edge", a_s_rdy, 1'b1);

        // Test 1: 4x2 frame, LSBs 10110010
        ba = got_a.size();
        lat_en = 1'b1;
        send_bits(16'hB2, 8, 4, 1'b1);
        idle(1);
        lat_en = 1'b0;
        idle(4);
        chk("t1_nbytes", got_a.size() - ba, 1);
        expect_byte("t1_byte", 1'b0, ba, {1'b1, 8'hB2});

        // Test 2: 4x1 frame flush
        bb = got_b.size();
        send_bits(16'h000F, 4, 4, 1'b1);
        idle(5);
        chk("t2_nbytes", got_b.size() - bb, 1);
        expect_byte("t2_flush", 1'b1, bb, {1'b1, 8'hF0});

        // Test 3: stalled message path, six bytes into depth 4
        ba = got_a.size();
        m01_rdy = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            v = 8'(k * 17);
            send_bits({8'h00, v}, 8, 4, 1'b1);
        end
        idle(3);
        chk("t3_hold_vld", a_m01_vld, 1'b1);
        chk("t3_hold_dat", a_m01_dat, 8'h11);
        idle(3);
        chk("t3_hold_dat_stable", a_m01_dat, 8'h11);
        chk("t3_overflow", a_ovf, 1'b1);
        chk("t3_no_pop", got_a.size() - ba, 0);
`ifdef STREAM_DECODER_DROP_CNT_EN
        chk("t3_drop_cnt", a_drop, 16'd2);
`endif
        m01_rdy = 1'b1;
        idle(8);
        chk("t3_nbytes", got_a.size() - ba, 4);
        for (int k = 0; k < 4; k++) begin
            v = 8'((k + 1) * 17);
            expect_byte("t3_byte", 1'b0, ba + k, {1'b1, v});
        end
        chk("t3_sticky", a_ovf, 1'b1);
        chk("t3_video_drained", exp_q.size(), 0);

        // Push and pop on a full FIFO in the same cycle
        do_reset();
        ba = got_a.size();
        m01_rdy = 1'b0;
        send_bits(16'h81, 8, 4, 1'b1);
        send_bits(16'h42, 8, 4, 1'b1);
        send_bits(16'h24, 8, 4, 1'b1);
        send_bits(16'h18, 8, 4, 1'b1);
        send_bits(16'h7F, 7, 4, 1'b1);
        m01_rdy = 1'b1;
        send(1'b1, 1'b1, 1'b0);
        m01_rdy = 1'b0;
        chk("full_pushpop_no_ovf", a_ovf, 1'b0);
`ifdef STREAM_DECODER_DROP_CNT_EN
        chk("full_pushpop_drop_cnt", a_drop, 16'd0);
`endif
        m01_rdy = 1'b1;
        idle(8);
        chk("full_pushpop_nbytes", got_a.size() - ba, 5);
        expect_byte("full_pushpop_b0", 1'b0, ba, {1'b1, 8'h81});
        expect_byte("full_pushpop_b3", 1'b0, ba + 3, {1'b1, 8'h18});
        expect_byte("full_pushpop_b4", 1'b0, ba + 4, {1'b1, 8'hFF});

        // Mid-frame byte without tlast, pixel counter wrapping without tlast
        ba = got_a.size();
        send_bits(16'hC33C, 16, 0, 1'b1);
        idle(5);
        chk("wrap_nbytes", got_a.size() - ba, 2);
        expect_byte("wrap_b0", 1'b0, ba, {1'b0, 8'hC3});
        expect_byte("wrap_b1", 1'b0, ba + 1, {1'b1, 8'h3C});

        // Test 4: tuser after 5 bits discards the partial byte
        ba = got_a.size();
        send_bits(16'h001F, 5, 4, 1'b1);
        send_bits(16'h005A, 8, 4, 1'b1);
        idle(5);
        chk("t4_nbytes", got_a.size() - ba, 1);
        expect_byte("t4_byte", 1'b0, ba, {1'b1, 8'h5A});

        // Test 5: m00 ready toggling every cycle
        ba = got_a.size();
        tgl = 1'b1;
        t5_en = 1'b1;
        send_bits(16'hA55A, 16, 4, 1'b1);
        t5_en = 1'b0;
        tgl = 1'b0;
        idle(5);
        chk("t5_video_drained", exp_q.size(), 0);
        chk("t5_nbytes", got_a.size() - ba, 2);
        expect_byte("t5_b0", 1'b0, ba, {1'b1, 8'hA5});
        expect_byte("t5_b1", 1'b0, ba + 1, {1'b1, 8'h5A});

        // Test 6: reset pulse mid-frame
        m01_rdy = 1'b0;
        send_bits(16'h0077, 8, 4, 1'b1);
        send_bits(16'h0005, 3, 4, 1'b1);
        chk("t6_pre_m01_vld", a_m01_vld, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_m00_vld", a_m00_vld, 1'b0);
        chk("t6_rst_m01_vld", a_m01_vld, 1'b0);
        chk("t6_rst_s00_rdy", a_s_rdy, 1'b0);
        chk("t6_rst_m00_data", {a_m00_dat, a_m00_last, a_m00_keep, a_m00_user}, '0);
        chk("t6_rst_m01_data", {a_m01_last, a_m01_dat}, '0);
        idle(2);
        reset_n = 1'b1;
        ba = got_a.size();
        m01_rdy = 1'b1;
        send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        send_bits(16'h0096, 8, 4, 1'b1);
        idle(5);
        chk("t6_nbytes", got_a.size() - ba, 1);
        expect_byte("t6_byte", 1'b0, ba, {1'b1, 8'h96});
        chk("t6_ovf_clear", a_ovf, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/stream_decoder_top.md
STREAM_DECODER_TOP -- requirements
Module: stream_decoder_top

Interface
REQ-001 SHALL have parameter BITS_PER_PIX, default 24: pixel width, three 8-bit channels.
REQ-002 SHALL have parameter PIXELS_PER_LINE, default 1920: pixels per line.
REQ-003 SHALL have parameter LINES_PER_FRAME, default 1080: lines per frame.
REQ-004 SHALL have parameter MSG_FIFO_DEPTH, default 4: message-byte FIFO entries, power of 2.
REQ-005 SHALL have port clk, input, 1: sole clock, all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have s00_axis_tvalid/tready/tdata[BITS_PER_PIX-1:0]/tlast/tkeep[2:0]/tuser: stego-video AXI4-Stream slave; tuser marks the first pixel of a frame; tlast marks end of line.
REQ-008 SHALL have m00_axis_tvalid/tready/tdata/tlast/tkeep[2:0]/tuser, same widths: video pass-through master.
REQ-009 SHALL have m01_axis_tvalid out 1, m01_axis_tdata out 8, m01_axis_tlast out 1, m01_axis_tready in 1: recovered message-byte master.
REQ-010 SHALL have msg_overflow, output, 1: sticky flag, at least one message byte dropped.

Function
REQ-011 Video path SHALL be a 2-entry skid buffer carrying {tdata,tlast,tkeep,tuser} unmodified; s00_axis_tready = buffer not full; latency 1 cycle from an accepted beat to m00_axis_tvalid.
REQ-012 The video path SHALL never stall because of the message path.
REQ-013 On every accepted input beat (s00 tvalid && tready) the block SHALL extract bit = s00_axis_tdata[0], the channel-0 LSB.
REQ-014 Extracted bits SHALL pack MSB-first into an 8-bit shift register with a 3-bit bit counter; on the 8th bit the completed byte SHALL be pushed to the message FIFO.
REQ-015 Pixel counter (0..PIXELS_PER_LINE-1) and line counter (0..LINES_PER_FRAME-1) SHALL advance on accepted beats; pixel counter wraps on tlast or at PIXELS_PER_LINE-1.
REQ-016 An accepted beat with tuser=1 SHALL force both counters to 0 for that pixel and SHALL discard any partial byte; that beat's bit becomes bit 7 of a new byte.
REQ-017 End of frame is the accepted beat with tlast=1 and line counter = LINES_PER_FRAME-1. The byte completed or flushed there SHALL carry m01_axis_tlast=1.
REQ-018 A partial byte at end of frame SHALL be flushed, padded with zeros in the unfilled LSBs.
REQ-019 A push into a full message FIFO SHALL drop that byte and set msg_overflow; msg_overflow SHALL clear only on reset.
REQ-020 m01_axis_tvalid = FIFO not empty; a byte is popped on m01 tvalid && tready; FIFO latency is 1 cycle from push to tvalid.
REQ-021 A push and a pop in the same cycle on a full FIFO SHALL both succeed, with no overflow.
REQ-022 The message path SHALL hold its data while m01_axis_tready is low; it is AXI-stable.

Reset
REQ-023 While reset_n=0 SHALL hold all tvalid=0, s00_axis_tready=0, counters=0, shift register=0, FIFO empty, msg_overflow=0, and all data outputs 0.
REQ-024 Reset mid-frame SHALL discard buffered video beats and message bytes; decoding resumes at the next tuser beat. Bits before that tuser are extracted but discarded by REQ-016.
REQ-025 s00_axis_tready SHALL rise no earlier than the first clk edge after reset_n deasserts.

Configuration
REQ-026 Macro STREAM_DECODER_DROP_CNT_EN, when defined, SHALL add output msg_drop_cnt[15:0]: count of dropped bytes, saturating at 16'hFFFF, reset to 0.
REQ-027 Without STREAM_DECODER_DROP_CNT_EN the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Test 1: 4x2 frame (PIXELS_PER_LINE=4, LINES_PER_FRAME=2), LSBs 1,0,1,1,0,0,1,0, both readies high -> one m01 byte 8'hB2, tlast=1; 8 video beats out unchanged, each 1 cycle later.
REQ-029 Test 2: 4x1 frame, LSBs 1,1,1,1 -> flushed byte 8'hF0, tlast=1.
REQ-030 Test 3: m01_axis_tready=0, 6 bytes' worth of pixels, depth 4 -> 4 bytes held, msg_overflow=1, msg_drop_cnt=2 (macro on); video unaffected.
REQ-031 Test 4: tuser after 5 bits -> partial discarded; next 8 LSBs 0x5A -> byte 8'h5A.
REQ-032 Test 5: m00_axis_tready toggling 1/0 every cycle with continuous input -> no beat lost or duplicated; s00_axis_tready drops only when the buffer is full.
REQ-033 Test 6: reset_n pulsed low mid-frame -> all outputs reach reset values immediately; first byte after reset aligns to the next tuser.
